// File: rtl/enc_counter_if.sv
// Bundles the sample strobe, encoder pins, host strobes and the position /
// status results of the quadrature counter into one port.
interface enc_counter_if #(
  parameter int W = 16
);

  logic         smp_en;
  logic         enc_a;
  logic         enc_b;
  logic         enc_z;
  logic         latch;
  logic         clr;
  logic [W-1:0] count;
  logic [W-1:0] count_snap;
  logic [W-1:0] index_snap;
  logic         index_seen;
  logic         qerr;

  // Driving side: divider, encoder pins and SPI slave; reads the results.
  modport master (
    output smp_en, enc_a, enc_b, enc_z, latch, clr,
    input  count, count_snap, index_snap, index_seen, qerr
  );

  // Counter side: consumes the strobes and pins, produces the results.
  modport slave (
    input  smp_en, enc_a, enc_b, enc_z, latch, clr,
    output count, count_snap, index_snap, index_seen, qerr
  );

endinterface

// File: rtl/enc_counter.sv
// Quadrature encoder position counter.
// Raw A/B/Z pins are synchronized, glitch filtered on the shared sample
// strobe, then decoded into up/down steps of a wrapping position count.
// Also keeps a host snapshot (latch), an index snapshot (Z rising edge)
// and sticky index-seen / quadrature-error flags.
module enc_counter #(
  parameter int W   = 16,
  parameter int FLT = 3
) (
  input logic          clk,
  input logic          rst,
  enc_counter_if.slave bus
);

  // Filter threshold in the width of the per-pin stability counter.
  localparam logic [3:0] FLT_CNT = 4'(FLT);
  localparam logic [W-1:0] ONE = W'(1);

  // Decoded action for one clk, derived from previous vs current filtered AB.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ERR
  } step_e;

  // Pin vectors are ordered {z, b, a} throughout.
  logic [2:0]   raw_pins;
  logic [2:0]   sync_1;
  logic [2:0]   sync_2;
  logic [2:0]   filt;

  logic [1:0]   prev_ab;
  logic [1:0]   cur_ab;
  logic         z_prev;
  logic         z_rise;
  step_e        step;

  logic [W-1:0] count_q;
  logic [W-1:0] count_snap_q;
  logic [W-1:0] index_snap_q;
  logic         index_seen_q;
  logic         qerr_q;

  assign raw_pins = {bus.enc_z, bus.enc_b, bus.enc_a};

  // Two-flop synchronizer for the asynchronous encoder pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_pins;
      sync_2 <= sync_1;
    end
  end

  // One glitch filter per pin: the filtered state only follows the
  // synchronized pin once it has disagreed for FLT consecutive strobes;
  // any clk of agreement restarts the count.
  for (genvar i = 0; i < 3; i++) begin : g_filter
    logic [3:0] stab_cnt;
    logic       state;

    // Stability counter and filtered state for this pin.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stab_cnt <= '0;
        state    <= 1'b0;
      end else if (sync_2[i] == state) begin
        stab_cnt <= '0;
      end else if (bus.smp_en) begin
        if (stab_cnt + 4'd1 == FLT_CNT) begin
          state    <= sync_2[i];
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 4'd1;
        end
      end
    end

    assign filt[i] = state;
  end

  // Current filtered {A,B}; A is the most significant bit of the Gray code.
  assign cur_ab = {filt[0], filt[1]};
  assign z_rise = filt[2] & ~z_prev;

  // Remember last clk's filtered AB and Z for edge / direction detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab <= 2'b00;
      z_prev  <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      z_prev  <= filt[2];
    end
  end

  // Gray-code decode: one-bit moves give a direction, two-bit moves are errors.
  always_comb begin
    step = STEP_NONE;
    case ({prev_ab, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_UP;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_DOWN;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ERR;
      default:                                step = STEP_NONE;
    endcase
  end

  // Position count and sticky flags; clr wins over any same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      qerr_q       <= 1'b0;
      index_seen_q <= 1'b0;
    end else if (bus.clr) begin
      count_q      <= '0;
      qerr_q       <= 1'b0;
      index_seen_q <= 1'b0;
    end else begin
      case (step)
        STEP_UP:   count_q <= count_q + ONE;
        STEP_DOWN: count_q <= count_q - ONE;
        STEP_ERR:  qerr_q  <= 1'b1;
        default:   count_q <= count_q;
      endcase
      if (z_rise) begin
        index_seen_q <= 1'b1;
      end
    end
  end

  // Snapshots capture the count as it stood before this cycle's update;
  // clr deliberately leaves both snapshots alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_snap_q <= '0;
      index_snap_q <= '0;
    end else begin
      if (bus.latch) begin
        count_snap_q <= count_q;
      end
      if (z_rise) begin
        index_snap_q <= count_q;
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.count_snap = count_snap_q;
  assign bus.index_snap = index_snap_q;
  assign bus.index_seen = index_seen_q;
  assign bus.qerr       = qerr_q;

endmodule

// File: doc/enc_counter.md
ENC_COUNTER -- requirements
Module: enc_counter

Interface
REQ-001 SHALL have parameter W, default 16: position count width in bits.
REQ-002 SHALL have parameter FLT, default 3: filter depth in sample strobes, legal range 1..15.
REQ-003 SHALL have port clk  input  1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port smp_en  input  1: filter sample strobe, one clk wide, from the shared clock divider.
REQ-006 SHALL have ports enc_a, enc_b, enc_z  input  1 each: raw asynchronous quadrature A/B and index pins.
REQ-007 SHALL have port latch  input  1: one-cycle snapshot strobe, pulsed by the SPI slave at frame start.
REQ-008 SHALL have port clr  input  1: one-cycle synchronous clear of count and status.
REQ-009 SHALL have port count  output  W: live position count.
REQ-010 SHALL have port count_snap  output  W: count captured by latch, read over SPI.
REQ-011 SHALL have port index_snap  output  W: count captured at the index edge.
REQ-012 SHALL have ports index_seen and qerr  output  1 each: sticky status flags.

Function
REQ-013 SHALL pass enc_a/b/z through a 2-flop synchronizer clocked every clk.
REQ-014 SHALL give each input its own glitch filter: 4-bit stability counter plus a filtered-state register.
REQ-015 Filter counter SHALL reset to 0 on any clk where the synchronized value equals the filtered value.
REQ-016 Otherwise the counter SHALL increment on smp_en; the filtered value SHALL take the synchronized value on the smp_en that brings the counter to FLT, and the counter SHALL return to 0.
REQ-017 SHALL store the previous filtered {A,B} every clk and decode it against the current filtered {A,B}.
REQ-018 Forward Gray sequence 00->01->11->10->00 SHALL give count+1; the reverse sequence SHALL give count-1; no change SHALL give no update.
REQ-019 A simultaneous change of both filtered A and B SHALL set qerr (sticky) and leave count unchanged.
REQ-020 Count SHALL wrap modulo 2^W in both directions: max+1 -> 0, 0-1 -> all ones.
REQ-021 A filtered Z rising edge SHALL load index_snap with the count register value present before that cycle's update, and SHALL set index_seen (sticky).
REQ-022 latch SHALL load count_snap with the count register value present before that cycle's update or clear.
REQ-023 clr SHALL zero count and clear qerr and index_seen on the next edge; it SHALL override a same-cycle step, index set or qerr set; it SHALL NOT modify count_snap or index_snap.
REQ-024 Latency from an enc_a edge to the count change SHALL be 2 clk (synchronizer) + FLT smp_en strobes + 1 clk.
REQ-025 SHALL generate no combinational path from any input to any output; all outputs are registered.

Reset
REQ-026 rst SHALL asynchronously zero count, count_snap, index_snap, index_seen, qerr, synchronizers, filter counters, filtered states and the previous-AB register.
REQ-027 Inputs SHALL be ignored while rst is high; the first decode after release SHALL compare against AB=00.
REQ-028 rst asserted mid-transition SHALL discard any partially filtered edge.

Verification
REQ-029 FLT=3, smp_en every 4 clk, 8 forward quadrature cycles (32 edges) -> count=32, qerr=0.
REQ-030 count=0, one reverse edge -> count=16'hFFFF; then one forward edge -> count=0.
REQ-031 1-sample A glitch (shorter than FLT strobes) -> count unchanged, qerr=0.
REQ-032 A and B toggled in the same clk and held for FLT strobes -> qerr=1, count unchanged; then clr -> qerr=0, count=0.
REQ-033 Z rise in the same clk as a step from 5 to 6 -> index_snap=5, index_seen=1, count=6.
REQ-034 latch and clr in the same clk with count=100 -> count_snap=100, count=0; rst mid-filter -> all outputs 0 immediately.
